// File: rtl/memory_responder.sv
// memory_responder: fixed-latency pipelined main-memory responder for cache fills.
// Optional feature macro: MEM_REFRESH_EN (periodic one-cycle refresh stall).
// Every accepted request walks a LATENCY-deep pipeline; storage is touched
// only at the final stage so reads and writes commit in acceptance order.
module memory_responder #(
   parameter int LATENCY        = 4,
   parameter int WORDS_LOG2     = 15,
   parameter int REFRESH_PERIOD = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        MemoryRequest,
   input  logic        MemoryWrite,
   input  logic [15:0] MemoryAddressIn,
   input  logic [15:0] MemoryDataIn,
   output logic [15:0] MemoryDataOut,
   output logic [15:0] MemoryAddressOut,
   output logic        MemoryDataValid,
   output logic        MemoryStall
);

   localparam int DEPTH = 1 << WORDS_LOG2;

   if (LATENCY < 1 || LATENCY > 16 || REFRESH_PERIOD < 2) begin : gBadParams
      $error("memory_responder: LATENCY must be 1..16 and REFRESH_PERIOD at least 2");
   end

   logic [15:0]           mem [DEPTH];
   logic                  accept;
   logic                  finValid;
   logic                  finWrite;
   logic [15:0]           finAddr;
   logic [15:0]           finData;
   logic [WORDS_LOG2-1:0] finIndex;

   // A request is taken whenever no refresh stall is in progress
   always_comb accept = MemoryRequest && !MemoryStall;

   // With LATENCY 1 the output register is the only stage, so the final-stage
   // view is the incoming request itself; otherwise it is the last shift stage.
   if (LATENCY == 1) begin : gNoPipe
      // Final stage fed directly by the accepted request
      always_comb begin
         finValid = accept;
         finWrite = MemoryWrite;
         finAddr  = MemoryAddressIn;
         finData  = MemoryDataIn;
      end
   end else begin : gPipe
      localparam int unsigned STAGES = LATENCY - 1;
      logic        stValid [STAGES];
      logic        stWrite [STAGES];
      logic [15:0] stAddr  [STAGES];
      logic [15:0] stData  [STAGES];

      // Valid bits shift every cycle and are flushed by reset
      always_ff @(posedge clk) begin
         if (rst) begin
            for (int unsigned i = 0; i < STAGES; i++) stValid[i] <= 1'b0;
         end else begin
            stValid[0] <= accept;
            for (int unsigned i = 1; i < STAGES; i++) stValid[i] <= stValid[i-1];
         end
      end

      // Payload shifts unconditionally; it is meaningless unless its valid is set
      always_ff @(posedge clk) begin
         stWrite[0] <= MemoryWrite;
         stAddr[0]  <= MemoryAddressIn;
         stData[0]  <= MemoryDataIn;
         for (int unsigned i = 1; i < STAGES; i++) begin
            stWrite[i] <= stWrite[i-1];
            stAddr[i]  <= stAddr[i-1];
            stData[i]  <= stData[i-1];
         end
      end

      // Final stage is the oldest pipeline entry
      always_comb begin
         finValid = stValid[STAGES-1];
         finWrite = stWrite[STAGES-1];
         finAddr  = stAddr[STAGES-1];
         finData  = stData[STAGES-1];
      end
   end

   // Word index ignores bit 0 and any bits above the storage depth
   always_comb finIndex = finAddr[WORDS_LOG2:1];

   // Storage write at the final stage; a write reaching it on a reset edge is dropped
   always_ff @(posedge clk) begin
      if (!rst && finValid && finWrite) mem[finIndex] <= finData;
   end

   // Response register: read data and echoed address, zero when idle
   always_ff @(posedge clk) begin
      if (rst) begin
         MemoryDataOut    <= '0;
         MemoryAddressOut <= '0;
         MemoryDataValid  <= 1'b0;
      end else if (finValid && !finWrite) begin
         MemoryDataOut    <= mem[finIndex];
         MemoryAddressOut <= finAddr;
         MemoryDataValid  <= 1'b1;
      end else begin
         MemoryDataOut    <= '0;
         MemoryAddressOut <= '0;
         MemoryDataValid  <= 1'b0;
      end
   end

`ifdef MEM_REFRESH_EN
   localparam int CW = $clog2(REFRESH_PERIOD);
   localparam logic [CW-1:0] LAST_COUNT = CW'(REFRESH_PERIOD - 1);
   logic [CW-1:0] refreshCount;

   // Refresh counter runs 0..REFRESH_PERIOD-1 and wraps
   always_ff @(posedge clk) begin
      if (rst || refreshCount == LAST_COUNT) refreshCount <= '0;
      else                                   refreshCount <= refreshCount + CW'(1);
   end

   // Stall for the single refresh cycle of each period
   always_comb MemoryStall = (refreshCount == LAST_COUNT);
`else
   // No refresh: requests are never refused
   always_comb MemoryStall = 1'b0;
`endif

endmodule
